// File: rtl/sw_alloc.sv
// Router switch allocator: per-output round-robin arbitration with downstream credit tracking.
// Define SW_ALLOC_LOCK_EN to hold an output for one packet (wormhole locking) until its tail is granted.
module sw_alloc #(
   parameter int NUM_PORTS    = 5,
   parameter int DIR_W        = 3,
   parameter int CREDIT_DEPTH = 5,
   parameter int CNT_W        = 3
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_PORTS-1:0]       req_valid,
   input  logic [NUM_PORTS*DIR_W-1:0] req_dir,
   input  logic [NUM_PORTS-1:0]       req_tail,
   input  logic [NUM_PORTS-1:0]       credit_in,
   output logic [NUM_PORTS-1:0]       grant,
   output logic [NUM_PORTS*DIR_W-1:0] xbar_sel,
   output logic [NUM_PORTS-1:0]       xbar_valid,
   output logic                       credit_err
);

   // Handshake: an input holds req_valid with its req_dir until it sees grant;
   // a request sampled at edge N is answered by grant/xbar_* registered at that edge.

   logic [CNT_W-1:0]     credit  [NUM_PORTS];
   logic [DIR_W-1:0]     ptr     [NUM_PORTS];
   logic [DIR_W-1:0]     ptr_d   [NUM_PORTS];
   logic [DIR_W-1:0]     win_idx [NUM_PORTS];
   logic [NUM_PORTS-1:0] win;
   logic [NUM_PORTS-1:0] gnt_d;
   logic                 err_d;

`ifdef SW_ALLOC_LOCK_EN
   logic [NUM_PORTS-1:0] lock;
   logic [DIR_W-1:0]     owner [NUM_PORTS];
   logic [NUM_PORTS-1:0] win_tail;
`else
   logic unused_tail;
   assign unused_tail = ^req_tail;
`endif

   always_comb begin : arbitrate
      int  idx;
      logic elig;
      idx  = 0;
      elig = 1'b0;
      win  = '0;
      for (int o = 0; o < NUM_PORTS; o++) win_idx[o] = '0;
      for (int o = 0; o < NUM_PORTS; o++) begin
         for (int k = 0; k < NUM_PORTS; k++) begin
            idx = int'(ptr[o]) + k;
            if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
            elig = req_valid[idx] && (req_dir[idx*DIR_W +: DIR_W] == DIR_W'(o)) &&
                   (credit[o] != '0);
`ifdef SW_ALLOC_LOCK_EN
            if (lock[o] && (owner[o] != DIR_W'(idx))) elig = 1'b0;
`endif
            if (!win[o] && elig) begin
               win[o]     = 1'b1;
               win_idx[o] = DIR_W'(idx);
            end
         end
      end
   end

   always_comb begin : next_ctl
      gnt_d = '0;
      err_d = credit_err;
      for (int o = 0; o < NUM_PORTS; o++) begin
         ptr_d[o] = ptr[o];
         if (win[o]) gnt_d[win_idx[o]] = 1'b1;
         if (credit_in[o] && !win[o] && (credit[o] == CNT_W'(CREDIT_DEPTH))) err_d = 1'b1;
`ifdef SW_ALLOC_LOCK_EN
         // A locked output keeps its pointer until the owner's tail goes through.
         if (win[o] && (!lock[o] || win_tail[o]))
`else
         if (win[o])
`endif
            ptr_d[o] = (win_idx[o] == DIR_W'(NUM_PORTS-1)) ? '0 : win_idx[o] + DIR_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant      <= '0;
         xbar_valid <= '0;
         xbar_sel   <= '0;
         credit_err <= 1'b0;
         for (int o = 0; o < NUM_PORTS; o++) begin
            credit[o] <= CNT_W'(CREDIT_DEPTH);
            ptr[o]    <= '0;
         end
      end else begin
         grant      <= gnt_d;
         xbar_valid <= win;
         credit_err <= err_d;
         for (int o = 0; o < NUM_PORTS; o++) begin
            xbar_sel[o*DIR_W +: DIR_W] <= win[o] ? win_idx[o] : '0;
            ptr[o] <= ptr_d[o];
            // A win and a returned credit in the same cycle cancel out.
            if (win[o] && !credit_in[o])
               credit[o] <= credit[o] - CNT_W'(1);
            else if (!win[o] && credit_in[o] && (credit[o] != CNT_W'(CREDIT_DEPTH)))
               credit[o] <= credit[o] + CNT_W'(1);
         end
      end
   end

`ifdef SW_ALLOC_LOCK_EN
   always_comb begin
      win_tail = '0;
      for (int o = 0; o < NUM_PORTS; o++) win_tail[o] = win[o] && req_tail[win_idx[o]];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lock <= '0;
         for (int o = 0; o < NUM_PORTS; o++) owner[o] <= '0;
      end else begin
         for (int o = 0; o < NUM_PORTS; o++) begin
            if (win[o] && !lock[o] && !win_tail[o]) begin
               lock[o]  <= 1'b1;
               owner[o] <= win_idx[o];
            end else if (win[o] && lock[o] && win_tail[o]) begin
               lock[o] <= 1'b0;
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_sw_alloc.sv
// Bench for sw_alloc: directed scenarios plus random traffic against a per-cycle behavioural model.
module tb_sw_alloc;

`ifdef SW_ALLOC_LOCK_EN
   localparam bit LOCK = 1'b1;
`else
   localparam bit LOCK = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [4:0]  req_valid = '0;
   logic [14:0] req_dir = '0;
   logic [4:0]  req_tail = '0;
   logic [4:0]  credit_in = '0;
   logic [4:0]  grant;
   logic [14:0] xbar_sel;
   logic [4:0]  xbar_valid;
   logic        credit_err;

   int checks = 0;
   int errors = 0;

   // behavioural model state
   int m_cred[5];
   int m_ptr[5];
   bit m_lock[5];
   int m_owner[5];
   bit m_err;

   sw_alloc dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_dir(req_dir), .req_tail(req_tail),
      .credit_in(credit_in), .grant(grant), .xbar_sel(xbar_sel), .xbar_valid(xbar_valid),
      .credit_err(credit_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int o = 0; o < 5; o++) begin
         m_cred[o] = 5; m_ptr[o] = 0; m_lock[o] = 0; m_owner[o] = 0;
      end
      m_err = 0;
   endtask

   // Asserts reset mid-cycle and checks the outputs clear without waiting for a clock edge.
   task automatic do_reset();
      #2 rst = 1'b1;
      req_valid = '0; req_dir = '0; req_tail = '0; credit_in = '0;
      #1;
      check("rst_grant", 32'(grant), 0);
      check("rst_xvalid", 32'(xbar_valid), 0);
      check("rst_xsel", 32'(xbar_sel), 0);
      check("rst_err", 32'(credit_err), 0);
      model_reset();
      @(posedge clk); #1;
      for (int o = 0; o < 5; o++) check($sformatf("rst_credit%0d", o), 32'(dut.credit[o]), 5);
      rst = 1'b0;
   endtask

   // One clock of stimulus; the model predicts the registered outputs from the rules.
   task automatic cycle(input logic [4:0] v, input logic [14:0] d, input logic [4:0] t,
                        input logic [4:0] c);
      int w[5];
      logic [4:0] exp_g;
      logic [4:0] exp_v;
      int i;
      exp_g = '0; exp_v = '0;
      for (int o = 0; o < 5; o++) begin
         w[o] = -1;
         for (int k = 0; k < 5; k++) begin
            i = (m_ptr[o] + k) % 5;
            if (w[o] < 0 && v[i] && int'(d[i*3 +: 3]) == o && m_cred[o] > 0 &&
                (!LOCK || !m_lock[o] || m_owner[o] == i))
               w[o] = i;
         end
         if (w[o] >= 0) begin exp_g[w[o]] = 1'b1; exp_v[o] = 1'b1; end
      end
      for (int o = 0; o < 5; o++) begin
         if (w[o] >= 0 && !c[o]) m_cred[o]--;
         else if (w[o] < 0 && c[o]) begin
            if (m_cred[o] == 5) m_err = 1; else m_cred[o]++;
         end
         if (w[o] >= 0) begin
            if (LOCK && m_lock[o]) begin
               if (t[w[o]]) begin m_lock[o] = 0; m_ptr[o] = (w[o] + 1) % 5; end
            end else begin
               m_ptr[o] = (w[o] + 1) % 5;
               if (LOCK && !t[w[o]]) begin m_lock[o] = 1; m_owner[o] = w[o]; end
            end
         end
      end
      req_valid = v; req_dir = d; req_tail = t; credit_in = c;
      @(posedge clk); #1;
      check("grant", 32'(grant), 32'(exp_g));
      check("xvalid", 32'(xbar_valid), 32'(exp_v));
      for (int o = 0; o < 5; o++) begin
         if (exp_v[o]) check($sformatf("xsel%0d", o), 32'(xbar_sel[o*3 +: 3]), w[o]);
         check($sformatf("credit%0d", o), 32'(dut.credit[o]), m_cred[o]);
      end
      check("credit_err", 32'(credit_err), 32'(m_err));
   endtask

   initial begin
      int cnt;
      int first4;
      int fidx;
      logic [4:0] v, t;
      logic [4:0] seq[4];

      do_reset();
      cycle('0, '0, '0, '0);
      check("idle_grant", 32'(grant), 0);

      // inputs 1 and 3 contend for E with a credit returned every cycle
      for (int n = 0; n < 4; n++) begin
         cycle(5'b01010, {3'd0, 3'd2, 3'd0, 3'd2, 3'd0}, '0, 5'b00100);
         seq[n] = grant;
      end
      check("alt0", 32'(seq[0]), 32'h2);
      check("alt1", 32'(seq[1]), 32'h8);
      check("alt2", 32'(seq[2]), 32'h2);
      check("alt3", 32'(seq[3]), 32'h8);
      check("alt_credit", 32'(dut.credit[2]), 5);

      // credit exhaustion on W
      do_reset();
      cnt = 0;
      for (int n = 0; n < 6; n++) begin
         cycle(5'b00001, {12'd0, 3'd4}, '0, '0);
         cnt += int'(grant[0]);
      end
      check("exhaust_grants", cnt, 5);
      check("exhaust_credit", 32'(dut.credit[4]), 0);
      cnt = 0;
      cycle(5'b00001, {12'd0, 3'd4}, '0, 5'b10000);
      cnt += int'(grant[0]);
      for (int n = 0; n < 2; n++) begin
         cycle(5'b00001, {12'd0, 3'd4}, '0, '0);
         cnt += int'(grant[0]);
      end
      check("refill_grants", cnt, 1);

      // full permutation
      do_reset();
      cycle(5'b11111, {3'd0, 3'd4, 3'd3, 3'd2, 3'd1}, '0, '0);
      check("perm_grant", 32'(grant), 32'h1f);

      // credit overflow is sticky until reset
      do_reset();
      cycle('0, '0, '0, 5'b01000);
      check("ovf_err", 32'(credit_err), 1);
      check("ovf_credit", 32'(dut.credit[3]), 5);
      for (int n = 0; n < 3; n++) cycle('0, '0, '0, '0);
      check("ovf_sticky", 32'(credit_err), 1);

      // packet from input 2 to N against single-flit traffic from input 4
      do_reset();
      fidx = 0; first4 = -1;
      for (int n = 0; n < 7; n++) begin
         v = {1'b1, 1'b0, (fidx < 4), 2'b00};
         t = {1'b1, 1'b0, (fidx == 3), 2'b00};
         cycle(v, {3'd1, 3'd0, 3'd1, 3'd0, 3'd0}, t, 5'b00010);
         if (grant[2]) fidx++;
         if (grant[4] && first4 < 0) first4 = n;
      end
      check("lock_first4", first4, LOCK ? 4 : 1);

      // random traffic, including reserved directions and sporadic credit returns
      do_reset();
      for (int n = 0; n < 400; n++) begin
         logic [14:0] d;
         for (int i = 0; i < 5; i++) d[i*3 +: 3] = 3'($urandom_range(0, 7));
         cycle(5'($urandom), d, 5'($urandom),
               5'(($urandom_range(0, 3) == 0) ? $urandom : 0));
         if (n == 200) do_reset();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
